seg7_source_sched: RTL and testbench
====================================

// Module: seg7_source_sched
// PURPOSE
//  Feeds the 4-digit seven-segment driver. Selects one of four 16-bit processor
//  debug values (e.g. PC, ALU result, x10, load data) and converts it to four BCD
//  digits using a sequential double-dabble (one shift per clock). Re-converts on a
//  periodic refresh tick and whenever the selected source changes. The source
//  advances automatically (dwell timer) or manually (btn_next pulse).
// PARAMETERS
//  WIDTH           16          source width, legal 8..16; double-dabble runs WIDTH shifts
//  REFRESH_CYCLES  10_000_000  clk cycles between refresh ticks (100 ms @ 100 MHz)
//  DWELL_TICKS     20          refresh ticks per source in auto mode (>=1)
// PORTS
//  clk_100MHz  in   1      system clock
//  reset_n     in   1      asynchronous active-low reset
//  src0..src3  in   WIDTH  candidate display values, unsigned
//  auto_mode   in   1      1: rotate on dwell timer, btn_next ignored; 0: manual
//  btn_next    in   1      debounced single-cycle pulse, next source (manual only)
//  ones        out  4      BCD units digit
//  tens        out  4      BCD tens digit
//  hundreds    out  4      BCD hundreds digit
//  thousands   out  4      BCD thousands digit; 4'hF = overflow ('E')
//  src_idx     out  2      currently selected source
//  busy        out  1      conversion in progress (state != IDLE)
//  upd         out  1      1-cycle pulse, digits just updated
// BEHAVIOUR
//  Reset (async, reset_n=0): digits=0, src_idx=0, busy=0, upd=0, all counters 0,
//   state IDLE, pending=1, so one conversion starts right after reset release.
//  Refresh counter: counts 0..REFRESH_CYCLES-1 and wraps. tick=1 on the wrap cycle.
//  Dwell counter (auto_mode=1 only): counts ticks 0..DWELL_TICKS-1. On wrap,
//   src_idx+1 (mod 4, 3->0). Cleared while auto_mode=0.
//  Manual: btn_next with auto_mode=0 -> src_idx+1 mod 4 on that edge.
//  Trigger = tick OR src_idx change OR pending. In IDLE, a trigger moves to LOAD and
//   clears pending. In any other state, a trigger sets pending. pending is one deep:
//   any number of triggers during one conversion yields exactly one follow-up.
//  FSM: IDLE -> LOAD -> SHIFT (WIDTH cycles, cnt 0..WIDTH-1) -> DONE -> IDLE.
//   LOAD: capture src[src_idx] into the shift register and clear the 20-bit BCD
//    scratch (5 digits).
//   SHIFT: for each scratch digit >=5, add 3; then shift {bcd,bin} left by 1.
//   DONE: write output digits, upd=1 for the next cycle.
//  Latency: trigger sampled at edge E0. Digits and upd are valid after edge
//   E(WIDTH+2), i.e. after E18 for WIDTH=16.
//  Output digits change only on the DONE edge; no intermediate values are visible.
//   The value converted is the one captured in LOAD. Source changes after LOAD
//   go to pending.
//  Overflow: if the ten-thousands digit != 0, thousands=4'hF. ones/tens/hundreds
//   keep the low three decimal digits.
//  Simultaneous tick and btn_next: src_idx advances, and a single trigger results.
//  Reset mid-conversion: aborts immediately. Outputs return to reset values.
// TESTING
//  (bench: REFRESH_CYCLES=100, DWELL_TICKS=2)
//  1 src0=1234, auto_mode=0, release reset -> after 18 edges digits 1,2,3,4
//    (thousands..ones); upd high 1 cycle; src_idx=0; busy low after.
//  2 src0=9999 -> 9,9,9,9. src0=10000 -> F,0,0,0. src0=65535 -> F,5,3,5.
//    src0=0 -> 0,0,0,0.
//  3 Manual: src1..3 = 1,22,333; four btn_next pulses -> src_idx 1,2,3,0, and each
//    conversion shows the matching value (0,0,0,1 / 0,0,2,2 / 0,3,3,3 / src0).
//  4 btn_next plus a tick during SHIFT -> exactly one extra conversion; first upd
//    shows old source, second shows new. Digits stay stable between the two upds.
//  5 auto_mode=1 -> src_idx advances every 200 cycles, wraps 3->0; btn_next pulses
//    have no effect; upd every 100 cycles.
//  6 reset_n low at SHIFT cnt=7 -> digits=0, busy=0 in the same cycle. After
//    release, one conversion runs with no tick needed.

Source files
------------

// File: rtl/seg7_source_sched_if.sv
// seg7_source_sched_if
//  Bundles the display-source bus of seg7_source_sched.
//  master: drives the four candidate values and the mode/button controls,
//          and receives the BCD digits and status.
//  slave : the scheduler/converter itself.
//  Signals:
//   src0..src3  WIDTH  candidate display values, unsigned
//   auto_mode   1      1: rotate on dwell timer, 0: manual via btn_next
//   btn_next    1      single-cycle pulse, advance source (manual only)
//   ones..thousands 4  BCD digits, thousands=4'hF means overflow
//   src_idx     2      currently selected source
//   busy        1      conversion in progress
//   upd         1      one-cycle pulse, digits just updated
interface seg7_source_sched_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] src0;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic [WIDTH-1:0] src3;
  logic             auto_mode;
  logic             btn_next;
  logic [3:0]       ones;
  logic [3:0]       tens;
  logic [3:0]       hundreds;
  logic [3:0]       thousands;
  logic [1:0]       src_idx;
  logic             busy;
  logic             upd;

  modport master (
    output src0, src1, src2, src3, auto_mode, btn_next,
    input  ones, tens, hundreds, thousands, src_idx, busy, upd
  );

  modport slave (
    input  src0, src1, src2, src3, auto_mode, btn_next,
    output ones, tens, hundreds, thousands, src_idx, busy, upd
  );
endinterface

// File: rtl/seg7_source_sched.sv
// seg7_source_sched
//  Picks one of four debug values and converts it to four BCD digits with a
//  sequential double-dabble (one shift per clock). A conversion is started by
//  the periodic refresh tick, by a change of the selected source, or by a
//  request left pending from a previous busy period.
//  Ports:
//   clk_100MHz  system clock
//   reset_n     asynchronous active-low reset
//   bus         seg7_source_sched_if.slave (sources, controls, digits, status)
module seg7_source_sched #(
  parameter int WIDTH          = 16,
  parameter int REFRESH_CYCLES = 10_000_000,
  parameter int DWELL_TICKS    = 20
) (
  input  logic               clk_100MHz,
  input  logic               reset_n,
  seg7_source_sched_if.slave bus
);

  localparam int RC_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int DW_W  = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(REFRESH_CYCLES - 1);
  localparam logic [DW_W-1:0]  DW_LAST  = DW_W'(DWELL_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t           state_reg, state_next;
  logic             pending_reg, pending_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] bin_reg, bin_next;
  logic [19:0]      bcd_reg, bcd_next;
  logic [15:0]      digits_reg, digits_next;
  logic             upd_reg, upd_next;
  logic [1:0]       src_idx_reg;
  logic [RC_W-1:0]  refresh_cnt_reg;
  logic [DW_W-1:0]  dwell_cnt_reg;

  logic             tick;
  logic             dwell_wrap;
  logic             advance;
  logic             trigger;
  logic [WIDTH-1:0] src_sel;
  logic [19:0]      bcd_adj;

  assign tick       = (refresh_cnt_reg == RC_LAST);
  assign dwell_wrap = bus.auto_mode && tick && (dwell_cnt_reg == DW_LAST);
  // Every advance changes src_idx, so it doubles as the "source changed" trigger.
  assign advance    = dwell_wrap || (!bus.auto_mode && bus.btn_next);
  assign trigger    = tick || advance || pending_reg;

  // Refresh timer, dwell timer and source index
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      refresh_cnt_reg <= '0;
      dwell_cnt_reg   <= '0;
      src_idx_reg     <= 2'd0;
    end else begin
      refresh_cnt_reg <= tick ? '0 : refresh_cnt_reg + 1'b1;
      if (!bus.auto_mode) begin
        dwell_cnt_reg <= '0;
      end else if (tick) begin
        dwell_cnt_reg <= dwell_wrap ? '0 : dwell_cnt_reg + 1'b1;
      end
      if (advance) begin
        src_idx_reg <= src_idx_reg + 2'd1;
      end
    end
  end

  always_comb begin
    case (src_idx_reg)
      2'd0:    src_sel = bus.src0;
      2'd1:    src_sel = bus.src1;
      2'd2:    src_sel = bus.src2;
      default: src_sel = bus.src3;
    endcase
  end

  // Double-dabble correction: any digit of 5 or more gets +3 before the shift
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                  bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
    end
  endgenerate

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      pending_reg <= 1'b1;
      cnt_reg     <= '0;
      bin_reg     <= '0;
      bcd_reg     <= '0;
      digits_reg  <= '0;
      upd_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      cnt_reg     <= cnt_next;
      bin_reg     <= bin_next;
      bcd_reg     <= bcd_next;
      digits_reg  <= digits_next;
      upd_reg     <= upd_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    cnt_next     = cnt_reg;
    bin_next     = bin_reg;
    bcd_next     = bcd_reg;
    digits_next  = digits_reg;
    upd_next     = 1'b0;

    // One-deep request latch: any trigger while busy leaves one follow-up
    if (state_reg != IDLE && trigger) begin
      pending_next = 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (trigger) begin
          state_next   = LOAD;
          pending_next = 1'b0;
        end
      end
      LOAD: begin
        bin_next   = src_sel;
        bcd_next   = '0;
        cnt_next   = '0;
        state_next = SHIFT;
      end
      SHIFT: begin
        {bcd_next, bin_next} = {bcd_adj, bin_reg} << 1;
        if (cnt_reg == CNT_LAST) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        // A non-zero ten-thousands digit is shown as 'E' in the thousands place
        digits_next = {(bcd_reg[19:16] != 4'd0) ? 4'hF : bcd_reg[15:12],
                       bcd_reg[11:0]};
        upd_next    = 1'b1;
        state_next  = IDLE;
      end
    endcase
  end

  assign bus.ones      = digits_reg[3:0];
  assign bus.tens      = digits_reg[7:4];
  assign bus.hundreds  = digits_reg[11:8];
  assign bus.thousands = digits_reg[15:12];
  assign bus.src_idx   = src_idx_reg;
  assign bus.busy      = (state_reg != IDLE);
  assign bus.upd       = upd_reg;

endmodule

// File: tb/tb_seg7_source_sched.sv
module tb_seg7_source_sched;

  localparam int WIDTH = 16;
  localparam int RC    = 100;
  localparam int DT    = 2;

  logic clk_100MHz = 1'b0;
  logic reset_n    = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  seg7_source_sched_if #(.WIDTH(WIDTH)) bus ();

  seg7_source_sched #(
    .WIDTH(WIDTH),
    .REFRESH_CYCLES(RC),
    .DWELL_TICKS(DT)
  ) dut (
    .clk_100MHz(clk_100MHz),
    .reset_n(reset_n),
    .bus(bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] disp;
  assign disp = {bus.thousands, bus.hundreds, bus.tens, bus.ones};

  int unsigned src_m [4];

  typedef struct {
    int unsigned value;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl [8];

  // Reference conversion from plain decimal arithmetic
  function automatic logic [15:0] to_digits(input int unsigned v);
    logic [3:0] th, h, t, o;
    th = (v >= 10000) ? 4'hF : 4'((v / 1000) % 10);
    h  = 4'((v / 100) % 10);
    t  = 4'((v / 10) % 10);
    o  = 4'(v % 10);
    return {th, h, t, o};
  endfunction

  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end else begin
      $display("ok   %s = %0h", name, got);
    end
  endtask

  task automatic step();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic set_srcs();
    bus.src0 = src_m[0][WIDTH-1:0];
    bus.src1 = src_m[1][WIDTH-1:0];
    bus.src2 = src_m[2][WIDTH-1:0];
    bus.src3 = src_m[3][WIDTH-1:0];
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (bus.busy && k < 100) begin
      step();
      k++;
    end
    if (bus.busy) check("wait_idle", 1, 0);
  endtask

  // Pulse btn_next, then watch for cyc cycles; returns upd count and last digits
  task automatic btn_and_settle(input int cyc, output int n_upd, output logic [15:0] last);
    n_upd = 0;
    last  = 16'h0;
    bus.btn_next = 1'b1;
    step();
    bus.btn_next = 1'b0;
    for (int i = 0; i < cyc; i++) begin
      step();
      if (bus.upd) begin
        n_upd++;
        last = disp;
      end
    end
  endtask

  initial begin
    int          edges;
    int          n_upd;
    int          midx;
    logic [15:0] last;
    logic [15:0] first_d, second_d;
    int          changes;
    int          found;

    src_m = '{0, 0, 0, 0};
    set_srcs();
    bus.auto_mode = 1'b0;
    bus.btn_next  = 1'b0;

    tbl[0] = '{1234,  16'h1234};
    tbl[1] = '{9999,  16'h9999};
    tbl[2] = '{10000, 16'hF000};
    tbl[3] = '{65535, 16'hF535};
    tbl[4] = '{0,     16'h0000};
    tbl[5] = '{99,    16'h0099};
    tbl[6] = '{10999, 16'hF999};
    tbl[7] = '{1000,  16'h1000};

    // Reset state
    repeat (3) step();
    check("rst_digits", disp, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_upd", bus.upd, 0);
    check("rst_src_idx", bus.src_idx, 0);

    // Table: each value converted by the automatic post-reset conversion
    for (int v = 0; v < 8; v++) begin
      reset_n = 1'b0;
      src_m[0] = tbl[v].value;
      set_srcs();
      repeat (2) step();
      reset_n = 1'b1;
      edges = -1;
      for (int k = 1; k <= 40; k++) begin
        step();
        if (bus.upd) begin
          edges = k;
          break;
        end
      end
      check($sformatf("tbl%0d_latency", v), edges, 19);
      check($sformatf("tbl%0d_digits", v), disp, tbl[v].exp);
      check($sformatf("tbl%0d_src_idx", v), bus.src_idx, 0);
      step();
      check($sformatf("tbl%0d_upd_pulse", v), bus.upd, 0);
      check($sformatf("tbl%0d_busy_after", v), bus.busy, 0);
    end

    // Manual stepping through the four sources
    src_m = '{1234, 1, 22, 333};
    set_srcs();
    midx = 0;
    for (int i = 0; i < 4; i++) begin
      btn_and_settle(45, n_upd, last);
      midx = (midx + 1) % 4;
      check($sformatf("man%0d_src_idx", i), bus.src_idx, midx);
      check($sformatf("man%0d_upd_seen", i), (n_upd > 0), 1);
      check($sformatf("man%0d_digits", i), last, to_digits(src_m[midx]));
    end

    // Randomized manual traffic against the reference model
    for (int i = 0; i < 12; i++) begin
      for (int s = 0; s < 4; s++) src_m[s] = $urandom_range(0, 65535);
      set_srcs();
      btn_and_settle(45, n_upd, last);
      midx = (midx + 1) % 4;
      check($sformatf("rnd%0d_src_idx", i), bus.src_idx, midx);
      check($sformatf("rnd%0d_digits", i), last, to_digits(src_m[midx]));
      check($sformatf("rnd%0d_held", i), disp, to_digits(src_m[midx]));
    end

    // Tick and btn_next both during SHIFT -> exactly one follow-up conversion
    src_m = '{4321, 56, 7, 890};
    set_srcs();
    wait_idle();
    found = 0;
    for (int k = 0; k < 250; k++) begin
      step();
      if (bus.busy) begin
        found = 1;
        break;
      end
    end
    check("t4_tick_seen", found, 1);
    repeat (94) step();
    bus.btn_next = 1'b1;
    step();
    bus.btn_next = 1'b0;
    midx = (midx + 1) % 4;
    repeat (7) step();
    bus.btn_next = 1'b1;
    step();
    bus.btn_next = 1'b0;
    n_upd = 0;
    changes = 0;
    first_d = 16'h0;
    second_d = 16'h0;
    for (int k = 0; k < 75; k++) begin
      step();
      if (bus.upd) begin
        n_upd++;
        if (n_upd == 1) first_d = disp;
        if (n_upd == 2) second_d = disp;
      end else if (n_upd == 1 && disp != first_d) begin
        changes++;
      end
    end
    check("t4_upd_count", n_upd, 2);
    check("t4_first_digits", first_d, to_digits(src_m[midx]));
    check("t4_second_digits", second_d, to_digits(src_m[(midx + 1) % 4]));
    check("t4_stable_between", changes, 0);
    midx = (midx + 1) % 4;
    check("t4_src_idx", bus.src_idx, midx);

    // Auto rotation, btn_next ignored
    begin
      int last_chg;
      int last_upd;
      int prev_idx;
      int wraps;
      bus.auto_mode = 1'b1;
      last_chg = -1;
      last_upd = -1;
      prev_idx = bus.src_idx;
      changes = 0;
      wraps = 0;
      for (int c = 0; c < 1000; c++) begin
        bus.btn_next = ($urandom_range(0, 7) == 0);
        step();
        if (bus.src_idx != 2'(prev_idx)) begin
          check($sformatf("auto_c%0d_next_idx", c), bus.src_idx, (prev_idx + 1) % 4);
          if (last_chg >= 0) check($sformatf("auto_c%0d_dwell_gap", c), c - last_chg, 2 * RC);
          if (prev_idx == 3) wraps++;
          prev_idx = bus.src_idx;
          last_chg = c;
          changes++;
        end
        if (bus.upd) begin
          if (last_upd >= 0) check($sformatf("auto_c%0d_upd_gap", c), c - last_upd, RC);
          check($sformatf("auto_c%0d_digits", c), disp, to_digits(src_m[bus.src_idx]));
          last_upd = c;
        end
      end
      bus.btn_next = 1'b0;
      bus.auto_mode = 1'b0;
      check("auto_changes_ge4", (changes >= 4), 1);
      check("auto_wrap_seen", (wraps > 0), 1);
    end

    // Reset in the middle of SHIFT
    step();
    wait_idle();
    bus.btn_next = 1'b1;
    step();
    bus.btn_next = 1'b0;
    repeat (8) step();
    check("t6_in_shift", bus.busy, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_rst_digits", disp, 0);
    check("t6_rst_busy", bus.busy, 0);
    check("t6_rst_upd", bus.upd, 0);
    check("t6_rst_src_idx", bus.src_idx, 0);
    repeat (2) step();
    reset_n = 1'b1;
    n_upd = 0;
    last = 16'h0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (bus.upd) begin
        n_upd++;
        last = disp;
      end
    end
    check("t6_upd_count", n_upd, 1);
    check("t6_digits", last, to_digits(src_m[0]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
